// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller and the next-PC unit.
//   NUM_IRQ      : number of interrupt sources (fixed by the 2-bit int_num code)
//   INT_NUM_NONE : int_num value meaning "no interrupt"
//   irq_state_e  : controller state
//   npc_op_e     : next-PC select codes shared with the next-PC unit
package irq_ctrl_pkg;

    localparam int unsigned NUM_IRQ      = 3;
    localparam logic [1:0]  INT_NUM_NONE = 2'h3;

    typedef enum logic {
        IDLE,
        ISR
    } irq_state_e;

    typedef enum logic [2:0] {
        NPC_SEQ    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_IRQ    = 3'd3,
        NPC_ERET   = 3'd4
    } npc_op_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bus between the interrupt controller (master) and the core / next-PC unit
// (slave).
//   int_en, int_mask       : status-register enables
//   safe_point, resume_pc  : decode-stage boundary information
//   eret                   : handler return retires
//   irq_take, int_num, epc : take request, winning source, saved return address
//   in_service, pending    : status readback
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic                int_en;
    logic [NUM_IRQ-1:0]  int_mask;
    logic                safe_point;
    logic [31:0]         resume_pc;
    logic                eret;
    logic                irq_take;
    logic [1:0]          int_num;
    logic [31:0]         epc;
    logic                in_service;
    logic [NUM_IRQ-1:0]  pending;

    modport master (
        input  int_en, int_mask, safe_point, resume_pc, eret,
        output irq_take, int_num, epc, in_service, pending
    );

    modport slave (
        output int_en, int_mask, safe_point, resume_pc, eret,
        input  irq_take, int_num, epc, in_service, pending
    );

endinterface

// File: rtl/irq_ctrl_sync_edge.sv
// Single-bit synchroniser followed by a rising-edge detector.
//   clk, rst_n : core clock, asynchronous active-low reset
//   d          : raw asynchronous input
//   rise       : one-cycle pulse when the synchronised input goes 0 -> 1
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller feeding the next-PC unit.
//   clk, rst_n : core clock, asynchronous active-low reset
//   irq_in     : raw interrupt lines, rising edge requests service
//   bus        : irq_ctrl_if master side (enables, boundary info, take/epc/status)
// Source 0 has the highest priority. A take is raised combinationally at a
// safe point; the handler then runs without nesting until eret retires.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    irq_ctrl_if.master         bus
);

    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [1:0]         winner;
    logic [1:0]         int_num_r;
    logic [1:0]         int_num_d;
    logic [31:0]        epc_q;
    logic               take;
    logic               in_service;
    irq_state_e         state_q;
    irq_state_e         state_d;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (irq_in[i]),
            .rise (irq_edge[i])
        );
    end

    assign eligible = pending_q & bus.int_mask;

    // Lowest-numbered eligible source wins.
    always_comb begin
        winner = INT_NUM_NONE;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && winner == INT_NUM_NONE) begin
                winner = 2'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        int_num_d  = INT_NUM_NONE;
        in_service = 1'b0;
        case (state_q)
            IDLE: begin
                take = bus.int_en & bus.safe_point & (|eligible);
                if (take) begin
                    int_num_d = winner;
                    state_d   = ISR;
                end
            end
            ISR: begin
                in_service = 1'b1;
                int_num_d  = int_num_r;
                if (bus.eret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr = take ? (NUM_IRQ'(1) << winner) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            epc_q     <= '0;
            int_num_r <= INT_NUM_NONE;
        end else begin
            state_q   <= state_d;
            // Set after clear so a new edge on the source being taken survives.
            pending_q <= (pending_q & ~clr) | irq_edge;
            if (take) begin
                epc_q     <= bus.resume_pc;
                int_num_r <= winner;
            end else if (state_q == ISR && bus.eret) begin
                int_num_r <= INT_NUM_NONE;
            end
        end
    end

    assign bus.irq_take   = take;
    assign bus.int_num    = int_num_d;
    assign bus.epc        = epc_q;
    assign bus.in_service = in_service;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: a cycle-level reference model predicts the
// outputs of every cycle and every take; a monitor compares the DUT.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int unsigned SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] irq_in;

    irq_ctrl_if bus();

    irq_ctrl #(
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .irq_in(irq_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        take;
        logic [1:0]  num;
        logic        svc;
        logic [2:0]  pend;
        logic [31:0] epc;
    } exp_t;

    typedef struct {
        logic [1:0] num;
    } take_t;

    exp_t  exp_q[$];
    take_t take_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [2:0]  m_pend;
    bit        m_isr;
    bit [1:0]  m_num;
    bit [31:0] m_epc;
    // Raw input history: hist[k] = value driven k cycles ago
    bit [2:0]  hist[SYNC_STAGES+2];

    // Stimulus for the next cycle
    bit [2:0]  d_irq;
    bit        d_en;
    bit [2:0]  d_mask;
    bit        d_safe;
    bit [31:0] d_pc;
    bit        d_eret;
    bit        d_rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        bit [2:0] edges;
        bit [2:0] elig;
        bit       tk;
        bit [1:0] w;
        bit [1:0] num;
        @(negedge clk);
        rst_n        = ~d_rst;
        irq_in       = d_rst ? 3'b000 : d_irq;
        bus.int_en     = d_en;
        bus.int_mask   = d_mask;
        bus.safe_point = d_safe;
        bus.resume_pc  = d_pc;
        bus.eret       = d_eret;
        #1;
        if (d_rst) begin
            m_pend = '0;
            m_isr  = 1'b0;
            m_num  = 2'h3;
            m_epc  = '0;
            for (int k = 0; k < SYNC_STAGES + 2; k++) hist[k] = '0;
            exp_q.push_back('{take: 1'b0, num: 2'h3, svc: 1'b0, pend: 3'b000, epc: 32'h0});
            return;
        end
        for (int k = SYNC_STAGES + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d_irq;
        // A raw rise becomes pending SYNC_STAGES+1 cycles after it is driven.
        edges = hist[SYNC_STAGES] & ~hist[SYNC_STAGES+1];
        elig  = m_pend & d_mask;
        tk    = !m_isr && d_en && d_safe && (elig != 0);
        w     = 2'h3;
        for (int i = 2; i >= 0; i--) if (elig[i]) w = 2'(i);
        num   = m_isr ? m_num : (tk ? w : 2'h3);
        exp_q.push_back('{take: tk, num: num, svc: m_isr, pend: m_pend, epc: m_epc});
        if (tk) begin
            take_q.push_back('{num: w});
            m_pend[w] = 1'b0;
            m_isr     = 1'b1;
            m_num     = w;
            m_epc     = d_pc;
        end else if (m_isr && d_eret) begin
            m_isr = 1'b0;
            m_num = 2'h3;
        end
        m_pend = m_pend | edges;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compares every cycle's outputs and each take against the scoreboard.
    initial begin
        exp_t  e;
        take_t t;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("irq_take",   32'(bus.irq_take),   32'(e.take));
                check("int_num",    32'(bus.int_num),    32'(e.num));
                check("in_service", 32'(bus.in_service), 32'(e.svc));
                check("pending",    32'(bus.pending),    32'(e.pend));
                check("epc",        bus.epc,             e.epc);
                if (bus.irq_take === 1'b1) begin
                    if (take_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_take: got int_num %0d expected no take at %0t",
                                 bus.int_num, $time);
                    end else begin
                        t = take_q.pop_front();
                        check("take_num", 32'(bus.int_num), 32'(t.num));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        irq_in = '0;
        d_irq = '0; d_en = 1'b0; d_mask = '0; d_safe = 1'b0;
        d_pc = '0; d_eret = 1'b0; d_rst = 1'b1;
        run(2);
        d_rst = 1'b0;

        // Single request on source 1
        d_en = 1'b1; d_mask = 3'b111; d_safe = 1'b1; d_pc = 32'h1000;
        d_irq = 3'b010; run(6);
        d_eret = 1'b1; run(1); d_eret = 1'b0; d_irq = '0; run(2);

        // Priority: sources 2 and 0 together
        d_pc = 32'h2000; d_irq = 3'b101; run(6);
        d_eret = 1'b1; run(1); d_eret = 1'b0; d_pc = 32'h3000; run(3);
        d_eret = 1'b1; run(1); d_eret = 1'b0; d_irq = '0; run(2);

        // Deferral by safe_point
        d_safe = 1'b0; d_irq = 3'b001; run(8);
        d_safe = 1'b1; d_pc = 32'h4000; run(2);
        d_eret = 1'b1; run(1); d_eret = 1'b0; d_irq = '0; run(2);

        // Masking, then unmasking while in service for source 0
        d_mask = 3'b011; d_irq = 3'b100; run(6);
        d_irq = 3'b101; d_pc = 32'h5000; run(5);
        d_mask = 3'b111; run(4);
        d_eret = 1'b1; run(1); d_eret = 1'b0; d_pc = 32'h6000; run(3);
        d_eret = 1'b1; run(1); d_eret = 1'b0; d_irq = '0; run(2);

        // New edge on source 1 in the cycle source 1 is taken
        d_safe = 1'b0;
        d_irq = 3'b010; run(1);
        d_irq = 3'b000; run(1);
        d_irq = 3'b010; run(2);
        d_safe = 1'b1; d_pc = 32'h7000; run(3);
        d_eret = 1'b1; run(1); d_eret = 1'b0; d_pc = 32'h7100; run(3);
        d_eret = 1'b1; run(1); d_eret = 1'b0; d_irq = '0; run(2);

        // Reset mid-ISR
        d_irq = 3'b001; d_pc = 32'h8000; run(5);
        d_rst = 1'b1; run(1); d_rst = 1'b0; d_irq = '0; run(2);

        // eret while idle
        d_eret = 1'b1; run(3); d_eret = 1'b0; run(1);

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 3; b++) if ($urandom_range(3) == 0) d_irq[b] = ~d_irq[b];
            d_en   = ($urandom_range(7) != 0);
            d_mask = 3'($urandom);
            d_safe = ($urandom_range(3) != 0);
            d_pc   = $urandom;
            d_eret = ($urandom_range(3) == 0);
            d_rst  = ($urandom_range(99) == 0);
            step();
        end
        d_rst = 1'b0; d_eret = 1'b0; d_safe = 1'b0;
        run(1);
        @(negedge clk);
        #5;
        check("take_queue_drained", 32'(take_q.size()), 32'd0);
        check("exp_queue_drained",  32'(exp_q.size()),  32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Sequential interrupt controller that feeds the next-PC unit.
- Synchronises and latches three external interrupt sources, then arbitrates by fixed priority.
- At an architecturally safe instruction boundary it raises a take request with the winning int_num and captures the return address in epc.
- It holds in-service state until the handler's return (ERET) retires. The next-PC unit consumes irq_take/int_num to select the IRQ vector, and epc on return.

Parameters:
- NUM_IRQ, 3, number of interrupt sources (fixed at 3 to match the 2-bit int_num encoding; 2'h3 = none).
- SYNC_STAGES, 2, flip-flop stages on each irq_in bit before edge detection (legal values 2..3).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- irq_in  input  NUM_IRQ  raw asynchronous interrupt lines; rising edge requests service.
- int_en  input  1  global interrupt enable (status register bit).
- int_mask  input  NUM_IRQ  per-source enable, 1 = enabled.
- safe_point  input  1  current decode instruction is valid, not stalled, and not in a branch/jump delay slot.
- resume_pc  input  32  address to resume at if the interrupt is taken this cycle.
- eret  input  1  return instruction retires this cycle.
- irq_take  output  1  combinational: interrupt taken this cycle (next-PC unit selects the IRQ op).
- int_num  output  2  winning source during the take cycle; the latched source while in service; 2'h3 otherwise.
- epc  output  32  saved return address.
- in_service  output  1  handler active.
- pending  output  NUM_IRQ  latched pending bits, for status read.

Behaviour:
- Reset (async, rst_n=0): sync chains=0, edge history=0, pending=0, state=IDLE, epc=32'h0, int_num_r=2'h3. Outputs: irq_take=0, in_service=0, int_num=2'h3.
- Sync/edge: each irq_in[i] passes SYNC_STAGES flops. edge[i] = sync_out & ~prev. A raw rising edge sets pending[i] SYNC_STAGES+1 cycles later.
- Pending: set by edge[i] and cleared when source i is taken. If set and clear happen in the same cycle, set wins (the bit stays 1). Masked sources still latch pending and are not lost.
- Eligible = pending & int_mask. Priority: bit 0 highest, then 1, then 2.
- FSM states: IDLE, ISR.
- IDLE:
  - irq_take = int_en & safe_point & |eligible.
  - int_num = encoded winner when irq_take=1, else 2'h3.
  - On the clock edge with irq_take=1: epc<=resume_pc, int_num_r<=winner, pending[winner] cleared, state->ISR.
- ISR:
  - irq_take=0; in_service=1; int_num=int_num_r. No nesting; new edges only accumulate in pending.
  - eret=1: state->IDLE and int_num_r<=2'h3 on the next edge. The earliest next take is the cycle after eret.
  - epc is unchanged during ISR.
- eret in IDLE: ignored, no state change.
- int_en or int_mask deasserted while in ISR: no effect on the current handler.
- safe_point=0 defers the take indefinitely; pending is held.
- Reset mid-ISR: returns to IDLE immediately and discards all pending state.

Decomposition:
- Shared package/header holds: NUM_IRQ, INT_NUM_NONE (2'h3), IRQ state encoding, and the next-PC op codes shared with the next-PC unit.
- One sub-module, irq_sync_edge: per-bit synchroniser plus rising-edge detector, instantiated NUM_IRQ wide.
- Priority encoder and FSM stay in irq_ctrl.

Test Plan:
- Single request:
  - Stimulus: int_en=1, mask=3'b111, safe_point=1, resume_pc=32'h1000; irq_in[1] rises.
  - Response: pending=3'b010 at SYNC_STAGES+1 cycles; irq_take=1 with int_num=1 that cycle; next cycle epc=32'h1000, in_service=1, pending=0.
- Priority:
  - Stimulus: irq_in[2] and irq_in[0] rise together.
  - Response: first take int_num=0, pending=3'b100 left.
  - Then eret: return to IDLE, second take int_num=2, pending=0.
- Deferral:
  - Stimulus: pending=3'b001 with safe_point=0 for 5 cycles.
  - Response: irq_take=0 throughout, pending held; take occurs in the first cycle safe_point=1, with epc taken from resume_pc of that cycle.
- Masking and no nesting:
  - Stimulus: mask=3'b011 while irq_in[2] rises.
  - Response: pending=3'b100, no take.
  - Stimulus: set mask=3'b111 while in ISR for source 0.
  - Response: no take until after eret; then int_num=2.
- Set/clear collision:
  - Stimulus: a new edge on source 1 arrives in the same cycle source 1 is taken.
  - Response: pending[1]=1 after the edge; a second take follows the eret.
- Reset/eret edge cases:
  - Stimulus: rst_n pulsed low mid-ISR.
  - Response: in_service=0, int_num=2'h3, epc=0, pending=0 immediately.
  - Stimulus: eret asserted in IDLE.
  - Response: no state change.
